imem_fetch: RTL

// - Parametrised synchronous instruction memory with a valid/ready request/response interface.
// - Sits between the PC/fetch stage and decode.
// - Adds per-response stall holding, flush, and misaligned/out-of-range error reporting.
// - Optional loader write port.

---
 rtl/imem_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/imem_fetch.sv
// Instruction memory with one registered valid/ready response stage, flush and error reporting.
// Define IMEM_WRITE_PORT_EN to add a byte-enabled loader write port.
module imem_fetch #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
`ifdef IMEM_WRITE_PORT_EN
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be
`else
  output logic              rsp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t f_init();
    mem_t v;
    v = '0;
    if (INIT_FILE == "") begin
      v[0] = DATA_W'(32'hA000_0001);
      v[1] = DATA_W'(32'hA000_0002);
      v[2] = DATA_W'(32'hA000_0003);
      v[3] = DATA_W'(32'hA000_0004);
    end
    return v;
  endfunction

  mem_t r_mem = f_init();

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic [IDX_W-1:0]  w_ridx;
  logic              w_mis;
  logic              w_oor;
  logic              w_bad;
  logic              w_acc;
  logic [DATA_W-1:0] w_rd;

  assign w_ridx = req_addr[2 +: IDX_W];
  assign w_mis  = |req_addr[1:0];
  // any bit above the word index means the address lies past the array
  assign w_oor  = |(req_addr >> (IDX_W + 2));
  assign w_bad  = w_mis | w_oor;
  assign w_rd   = w_bad ? '0 : r_mem[w_ridx];

  assign req_ready = rst_n & ~flush & (~r_valid | rsp_ready);
  assign w_acc     = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_rd;
      r_addr  <= req_addr;
      r_err   <= w_bad;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;
  assign rsp_addr  = r_addr;
  assign rsp_err   = r_err;

`ifdef IMEM_WRITE_PORT_EN
  logic [IDX_W-1:0] w_widx;
  logic             w_wr_ok;

  assign w_widx  = wr_addr[2 +: IDX_W];
  assign w_wr_ok = wr_en & ~|wr_addr[1:0]
                 & ~|(wr_addr >> (IDX_W + 2));

  // read above samples the pre-write word, giving read-first behaviour
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_be[b]) r_mem[w_widx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
`endif

endmodule
